ceil_div_rr_sched: RTL
======================

// Module: ceil_div_rr_sched
// PURPOSE
//   Runtime counterpart of the elaboration-time ceil_div: one iterative ceiling divider shared by
//   NumReq requesters through a round-robin scheduler. Computes ceil(dividend/divisor) for one
//   operation at a time. Used by DMA/burst-splitting logic to get beat/chunk counts at run time.
// PARAMETERS
//   NumReq  4  number of requesters (>=1); index width = cf_math_pkg::idx_width(NumReq)
//   Width   8  operand and quotient width in bits (>=2)
// PORTS
//   clk_i         in   1              clock, single clock domain
//   rst_i         in   1              asynchronous reset, active-high
//   req_valid_i   in   NumReq         per-requester operation valid
//   req_ready_o   out  NumReq         one-hot accept; at most one bit high
//   dividend_i    in   NumReq*Width   per-requester dividend, unsigned
//   divisor_i     in   NumReq*Width   per-requester divisor, unsigned
//   resp_valid_o  out  1              result valid
//   resp_ready_i  in   1              result consumed
//   resp_idx_o    out  idx_t          requester index owning the result
//   resp_quot_o   out  Width          ceil(dividend/divisor)
//   resp_err_o    out  1              divide-by-zero flag
//   busy_o        out  1              high whenever state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, rr pointer 0. Reset mid-operation drops the op; no response.
//   States: IDLE -> BUSY -> DONE -> IDLE; IDLE -> DONE directly for divisor==0 (and early exit).
//   IDLE: grant = first valid requester at or after pointer (wrapping); req_ready_o[grant] is
//     combinational from req_valid_i, only in IDLE. Accept on valid&ready edge T: latch operands,
//     idx; pointer <= (grant+1) mod NumReq. Unaccepted requesters must hold valid and operands.
//   BUSY: restoring shift-subtract, one quotient bit per cycle, MSB first, exactly Width cycles.
//     Final cycle registers quot = q + (rem != 0). No overflow: divisor 1 gives rem 0; divisor>=2
//     gives q <= (2^Width-1)/2. resp_valid_o rises at edge T+Width.
//   divisor==0: resp_err_o=1, resp_quot_o = all-ones, resp_valid_o rises at edge T+1.
//   DONE: resp_* stable while resp_valid_o & ~resp_ready_i; no new grant. Handshake edge -> IDLE;
//     earliest next accept is the cycle after (one idle bubble per op, decided).
//   Inputs changing during BUSY/DONE have no effect on the in-flight op.
// CONFIGURATION
//   CEIL_DIV_SCHED_EARLY_EXIT_EN defined: accepted op with dividend < divisor (divisor != 0) skips
//     BUSY; quot = (dividend != 0) ? 1 : 0, resp_valid_o at edge T+1.
//   Not defined: every nonzero-divisor op takes the full Width-cycle BUSY; results identical.
// STRUCTURE
//   ceil_div_rr_sched_pkg: state_e enum {IDLE, BUSY, DONE}; idx_t = logic
//     [cf_math_pkg::idx_width(NumReq)-1:0] built via parameter type.
//   Sub-module ceil_div_rr_arb: round-robin pointer + one-hot grant; pointer update on accept only.
//   Divider datapath and FSM stay in the top module.
// TESTING (NumReq=4, Width=8)
//   Reset asserted mid-BUSY of 200/3 -> next cycle all outputs 0, busy_o 0, no response issued.
//   Req0 7/2, resp_ready_i=1 -> resp_quot_o 4, err 0, idx 0, resp_valid_o at edge T+8.
//   All four valid continuously with distinct ops -> accept order 0,1,2,3,0; one op per 10 cycles.
//   Req2 9/0 -> resp_err_o 1, resp_quot_o 8'hFF, idx 2, resp_valid_o at T+1.
//   255/1 -> 255; 6/3 -> 2; resp_ready_i low 5 cycles -> outputs stable, req_ready_o all 0.
//   3/10 -> 1 and 0/5 -> 0: latency T+1 with CEIL_DIV_SCHED_EARLY_EXIT_EN, T+8 without.

Source files
------------

// File: rtl/ceil_div_rr_sched_pkg.sv
// Types shared by the round-robin ceiling-divider scheduler.
package ceil_div_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cf_math_pkg.sv
// Shared elaboration-time math helpers.
package cf_math_pkg;

  // Bits needed to index num_idx items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/ceil_div_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer advances on accept only.
module ceil_div_rr_arb #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [NumReq-1:0] i_req,
  input  logic              i_accept,
  output logic [NumReq-1:0] o_gnt_c,
  output logic [IdxW-1:0]   o_idx_c
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_k;
  logic            w_found;

  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_k     = '0;
    w_found = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      w_k = IdxW'((32'(r_ptr) + off) % NumReq);
      if (i_en && !w_found && i_req[w_k]) begin
        o_gnt_c[w_k] = 1'b1;
        o_idx_c      = w_k;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (32'(o_idx_c) == NumReq - 1) ? '0 : o_idx_c + IdxW'(1);
    end
  end

endmodule

// File: rtl/ceil_div_rr_sched.sv
// Shared iterative ceil(dividend/divisor) unit serving NumReq requesters round-robin.
// Optional: CEIL_DIV_SCHED_EARLY_EXIT_EN skips iteration when dividend < divisor.
module ceil_div_rr_sched
  import ceil_div_rr_sched_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 8,
  parameter type idx_t = logic [cf_math_pkg::idx_width(NumReq)-1:0]
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] dividend_i,
  input  logic [NumReq*Width-1:0] divisor_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output idx_t                    resp_idx_o,
  output logic [Width-1:0]        resp_quot_o,
  output logic                    resp_err_o,
  output logic                    busy_o
);

  localparam int unsigned IdxW = $bits(idx_t);
  localparam int unsigned CntW = $clog2(Width);

  state_e             r_state, w_state_nxt;
  logic [Width-1:0]   r_dvd, r_dvs, r_rem, r_quot;
  logic [CntW-1:0]    r_cnt;
  idx_t               r_idx;
  logic               r_err;
  logic               r_resp_valid, r_resp_err, r_busy;
  logic [Width-1:0]   r_resp_quot;
  idx_t               r_resp_idx;

  logic [Width-1:0]   w_dvd_nxt, w_dvs_nxt, w_rem_nxt, w_quot_nxt, w_rquot_nxt;
  logic [CntW-1:0]    w_cnt_nxt;
  idx_t               w_idx_nxt, w_ridx_nxt;
  logic               w_err_nxt, w_rvalid_nxt, w_rerr_nxt;

  logic [NumReq-1:0]  w_gnt;
  logic [IdxW-1:0]    w_gnt_idx;
  logic               w_accept;
  logic [Width-1:0]   w_sel_dvd, w_sel_dvs;
  logic [Width:0]     w_rem_sh, w_diff;
  logic               w_ge, w_last;
  logic [Width-1:0]   w_rem_step, w_q_step, w_ceil;

  ceil_div_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_en     (r_state == IDLE),
    .i_req    (req_valid_i),
    .i_accept (w_accept),
    .o_gnt_c  (w_gnt),
    .o_idx_c  (w_gnt_idx)
  );

  assign req_ready_o = w_gnt;
  assign w_accept    = (r_state == IDLE) && (|w_gnt);

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_dvd = '0;
    w_sel_dvs = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_gnt[i]) begin
        w_sel_dvd = dividend_i[i*Width +: Width];
        w_sel_dvs = divisor_i[i*Width +: Width];
      end
    end
  end

  // One restoring step; remainder stays below divisor so the borrow bit decides the quotient bit.
  assign w_rem_sh   = {r_rem, r_dvd[Width-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_dvs};
  assign w_ge       = ~w_diff[Width];
  assign w_rem_step = w_ge ? w_diff[Width-1:0] : w_rem_sh[Width-1:0];
  assign w_q_step   = {r_dvd[Width-2:0], w_ge};
  assign w_ceil     = w_q_step + Width'(w_rem_step != '0);
  assign w_last     = (r_cnt == CntW'(Width - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_rem_nxt    = r_rem;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_quot_nxt   = r_quot;
    w_err_nxt    = r_err;
    w_rvalid_nxt = r_resp_valid;
    w_rquot_nxt  = r_resp_quot;
    w_rerr_nxt   = r_resp_err;
    w_ridx_nxt   = r_resp_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_idx_nxt = idx_t'(w_gnt_idx);
          w_dvd_nxt = w_sel_dvd;
          w_dvs_nxt = w_sel_dvs;
          w_rem_nxt = '0;
          w_cnt_nxt = '0;
          w_err_nxt = 1'b0;
          if (w_sel_dvs == '0) begin
            w_err_nxt   = 1'b1;
            w_quot_nxt  = '1;
            w_state_nxt = DONE;
          end
`ifdef CEIL_DIV_SCHED_EARLY_EXIT_EN
          else if (w_sel_dvd < w_sel_dvs) begin
            w_quot_nxt  = Width'(w_sel_dvd != '0);
            w_state_nxt = DONE;
          end
`endif
          else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        w_rem_nxt = w_rem_step;
        w_dvd_nxt = w_q_step;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_last) begin
          w_rvalid_nxt = 1'b1;
          w_rquot_nxt  = w_ceil;
          w_rerr_nxt   = 1'b0;
          w_ridx_nxt   = r_idx;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        // Short-path results enter DONE one cycle before they are presented.
        if (!r_resp_valid) begin
          w_rvalid_nxt = 1'b1;
          w_rquot_nxt  = r_quot;
          w_rerr_nxt   = r_err;
          w_ridx_nxt   = r_idx;
        end else if (resp_ready_i) begin
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_dvd        <= '0;
      r_dvs        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_quot       <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_quot  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_idx   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dvd        <= w_dvd_nxt;
      r_dvs        <= w_dvs_nxt;
      r_rem        <= w_rem_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_quot       <= w_quot_nxt;
      r_err        <= w_err_nxt;
      r_resp_valid <= w_rvalid_nxt;
      r_resp_quot  <= w_rquot_nxt;
      r_resp_err   <= w_rerr_nxt;
      r_resp_idx   <= w_ridx_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_quot_o  = r_resp_quot;
  assign resp_err_o   = r_resp_err;
  assign resp_idx_o   = r_resp_idx;
  assign busy_o       = r_busy;

endmodule
